// File: rtl/jk_mode_counter.sv
// jk_mode_counter: multi-mode WIDTH-bit counter whose state lives in JK flops.
//   Operations (mode): 00 count up/down with wrap at MODULUS, 01 load,
//   10 rotate left/right by one, 11 complement. Any load, rotate or
//   complement result >= MODULUS forces q to 0 and sets the sticky err flag.
//
// Ports
//   clk   in   rising-edge clock
//   reset in   synchronous active-high reset (q=0, err=0)
//   e     in   enable; 0 holds q and err
//   x     in   direction: 1 = up/left, 0 = down/right
//   mode  in   [1:0] operation select
//   d     in   [WIDTH-1:0] load data
//   q     out  [WIDTH-1:0] registered state
//   tc    out  combinational terminal count (cycle before a count wrap)
//   err   out  registered sticky out-of-range flag

module jkflipflop (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);
    logic q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q_q <= 1'b0;
                2'b10:   q_q <= 1'b1;
                2'b11:   q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q = q_q;
endmodule

module jk_mode_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e,
    input  logic             x,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             err
);
    // One extra bit so MODULUS == 2**WIDTH is representable for range checks.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] n_d;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic [WIDTH-1:0] rot_r;
    logic [WIDTH-1:0] cpl_r;
    logic             toggle_all;
    logic             err_q;
    logic             err_d;

    function automatic logic in_range(input logic [WIDTH-1:0] v);
        return ({1'b0, v} < MOD_EXT);
    endfunction

    assign rot_r = x ? {q_q[WIDTH-2:0], q_q[WIDTH-1]} : {q_q[0], q_q[WIDTH-1:1]};
    assign cpl_r = ~q_q;

    always_comb begin
        n_d        = q_q;
        err_d      = err_q;
        toggle_all = 1'b0;
        if (e) begin
            case (mode)
                2'b00: begin
                    if (x) n_d = (q_q == MAX_VAL) ? '0 : q_q + 1'b1;
                    else   n_d = (q_q == '0) ? MAX_VAL : q_q - 1'b1;
                end
                2'b01: begin
                    if (in_range(d)) begin
                        n_d   = d;
                        err_d = 1'b0;
                    end else begin
                        n_d   = '0;
                        err_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (in_range(rot_r)) begin
                        n_d = rot_r;
                    end else begin
                        n_d   = '0;
                        err_d = 1'b1;
                    end
                end
                default: begin
                    if (in_range(cpl_r)) begin
                        n_d        = cpl_r;
                        toggle_all = 1'b1;
                    end else begin
                        n_d   = '0;
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // A valid complement drives J=K=1 everywhere; otherwise J/K come from
    // the per-bit difference between current and next state.
    assign j_d = toggle_all ? '1 : (~q_q & n_d);
    assign k_d = toggle_all ? '1 : (q_q & ~n_d);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jkflipflop u_ff (
            .clk   (clk),
            .reset (reset),
            .j     (j_d[i]),
            .k     (k_d[i]),
            .q     (q_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign tc  = ~reset & e & (mode == 2'b00) & (x ? (q_q == MAX_VAL) : (q_q == '0));
    assign q   = q_q;
    assign err = err_q;
endmodule

// File: tb/tb_jk_mode_counter.sv
module tb_jk_mode_counter;
    localparam int MA = 10;
    localparam int MB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       e = 1'b0;
    logic       x = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] d_a = '0;
    logic [2:0] d_b = '0;
    logic [3:0] q_a;
    logic [2:0] q_b;
    logic       tc_a, tc_b, err_a, err_b;

    int n_checks = 0;
    int n_errors = 0;
    int mq_a = 0, merr_a = 0, mq_b = 0, merr_b = 0;

    always #5 clk = ~clk;

    jk_mode_counter #(.WIDTH(4), .MODULUS(MA)) u_dut_a (
        .clk(clk), .reset(reset), .e(e), .x(x), .mode(mode), .d(d_a),
        .q(q_a), .tc(tc_a), .err(err_a)
    );

    jk_mode_counter #(.WIDTH(3), .MODULUS(MB)) u_dut_b (
        .clk(clk), .reset(reset), .e(e), .x(x), .mode(mode), .d(d_b),
        .q(q_b), .tc(tc_b), .err(err_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour in plain integer arithmetic.
    task automatic model_step(input int w, input int m, input int q, input int err,
                              input bit en, input bit dir, input int md, input int dv,
                              output int nq, output int nerr);
        int full;
        int r;
        full = 1 << w;
        nq   = q;
        nerr = err;
        if (en) begin
            if (md == 0) begin
                nq = dir ? (q + 1) % m : (q + m - 1) % m;
            end else if (md == 1) begin
                if (dv < m) begin nq = dv; nerr = 0; end
                else        begin nq = 0;  nerr = 1; end
            end else begin
                if (md == 2) r = dir ? ((q * 2) % full + q / (full / 2))
                                     : (q / 2 + (q % 2) * (full / 2));
                else         r = full - 1 - q;
                if (r >= m) begin nq = 0; nerr = 1; end
                else        nq = r;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit en, input bit dir, input int md, input int dv);
        int nq, nerr;
        @(negedge clk);
        reset = r;
        e     = en;
        x     = dir;
        mode  = 2'(md);
        d_a   = 4'(dv);
        d_b   = 3'(dv);
        #1;
        chk("tc_a", int'(tc_a), int'(!r && en && md == 0 && (dir ? mq_a == MA - 1 : mq_a == 0)));
        chk("tc_b", int'(tc_b), int'(!r && en && md == 0 && (dir ? mq_b == MB - 1 : mq_b == 0)));
        @(posedge clk);
        if (r) begin
            mq_a = 0; merr_a = 0; mq_b = 0; merr_b = 0;
        end else begin
            model_step(4, MA, mq_a, merr_a, en, dir, md, dv % 16, nq, nerr);
            mq_a = nq; merr_a = nerr;
            model_step(3, MB, mq_b, merr_b, en, dir, md, dv % 8, nq, nerr);
            mq_b = nq; merr_b = nerr;
        end
        #1;
        chk("q_a", int'(q_a), mq_a);
        chk("err_a", int'(err_a), merr_a);
        chk("q_b", int'(q_b), mq_b);
        chk("err_b", int'(err_b), merr_b);
    endtask

    initial begin
        int up_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

        // Reset then up-count with wrap 9 -> 0
        cyc(1, 0, 0, 0, 0);
        chk("rst_q", int'(q_a), 0);
        chk("rst_err", int'(err_a), 0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1, 1, 0, 0);
            chk("up_seq", int'(q_a), up_seq[i]);
        end

        // Down wrap from 0, then hold
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("down_wrap", int'(q_a), 9);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 5);
        chk("hold_q", int'(q_a), 9);

        // Loads and sticky err
        cyc(0, 1, 0, 1, 7);
        chk("load7", int'(q_a), 7);
        cyc(0, 1, 0, 1, 12);
        chk("load12_err", int'(err_a), 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
        chk("count_keeps_err", int'(err_a), 1);
        cyc(0, 1, 0, 1, 3);
        chk("load3_clr", int'(err_a), 0);

        // Rotate
        cyc(0, 1, 1, 2, 0);
        chk("rotl_6", int'(q_a), 6);
        cyc(0, 1, 1, 2, 0);
        chk("rotl_oor", int'(err_a), 1);
        cyc(0, 1, 0, 1, 8);
        cyc(0, 1, 0, 2, 0);
        chk("rotr_4", int'(q_a), 4);

        // Complement
        cyc(0, 1, 0, 1, 6);
        cyc(0, 1, 1, 3, 0);
        chk("cpl_9", int'(q_a), 9);
        cyc(0, 1, 0, 3, 0);
        chk("cpl_6", int'(q_a), 6);
        cyc(0, 1, 0, 1, 2);
        cyc(0, 1, 0, 3, 0);
        chk("cpl_oor", int'(err_a), 1);

        // Reset mid-count overrides enable
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0);
        chk("at5", int'(q_a), 5);
        cyc(1, 1, 1, 0, 0);
        chk("midrst_q", int'(q_a), 0);
        cyc(0, 1, 1, 0, 0);
        chk("after_rst", int'(q_a), 1);

        // Smaller instance: full wrap 7 -> 0
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 0);
        chk("b_wrap", int'(q_b), 1);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/jk_mode_counter.md
JK_MODE_COUNTER -- requirements
Module: jk_mode_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, state width in bits; legal range 2..16.
REQ-002 SHALL have parameter MODULUS, default 2**WIDTH, count modulus; legal range 2..2**WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port e  input  1  enable; 0 = hold all state.
REQ-006 SHALL have port x  input  1  direction: 1 = up/left, 0 = down/right.
REQ-007 SHALL have port mode  input  2  operation select: 00 count, 01 load, 10 rotate, 11 complement.
REQ-008 SHALL have port d  input  WIDTH  load data.
REQ-009 SHALL have port q  output  WIDTH  current state, registered.
REQ-010 SHALL have port tc  output  1  terminal-count flag, combinational.
REQ-011 SHALL have port err  output  1  sticky out-of-range flag, registered.

Function
REQ-012 Each q bit SHALL be held in an instance of the team's existing jkflipflop cell; J/K per bit derived from the next-state value (J=~q&n, K=q&~n).
REQ-013 e=0 SHALL hold q and err unchanged regardless of mode, x, d.
REQ-014 Count (00), x=1: q <= q+1; at q=MODULUS-1, q <= 0 (wrap).
REQ-015 Count (00), x=0: q <= q-1; at q=0, q <= MODULUS-1 (wrap).
REQ-016 Load (01): d<MODULUS -> q <= d, err <= 0; d>=MODULUS -> q <= 0, err <= 1.
REQ-017 Rotate (10): x=1 rotate left by one bit over full WIDTH; x=0 rotate right by one; x ignored otherwise.
REQ-018 Complement (11): q <= ~q (all bits toggle, J=K=1 on every flop); x ignored.
REQ-019 Rotate/complement result r >= MODULUS: q <= 0, err <= 1; r < MODULUS: q <= r, err unchanged.
REQ-020 Count mode SHALL never set err; q always stays < MODULUS after any enabled count step.
REQ-021 tc SHALL be 1 iff e=1, mode=00, and (x=1 and q=MODULUS-1) or (x=0 and q=0); else 0.
REQ-022 tc SHALL be asserted in exactly the cycle preceding the wrap edge.
REQ-023 err SHALL clear only via reset or a valid load (REQ-016); no other mode clears it.
REQ-024 Latency: every operation SHALL take effect at the first rising clk edge after inputs are sampled; one operation per cycle.
REQ-025 Arithmetic SHALL be WIDTH-bit unsigned; no intermediate wider than WIDTH+1 bits visible on q.
REQ-026 Mode/direction change between cycles SHALL take effect immediately with no pipeline flush or dead cycle.

Reset
REQ-027 reset=1 at a rising edge SHALL force q=0, err=0, overriding e, mode, x, d.
REQ-028 reset asserted mid-count or mid-sequence SHALL abort it; next edge after reset deassertion SHALL operate from q=0.
REQ-029 tc SHALL be 0 while reset=1.
REQ-030 Without a reset edge, q and err are undefined; the bench SHALL apply reset for at least one edge first.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-031 reset=1 one edge, then e=1, mode=00, x=1 for 12 edges -> q: 1..9,0,1,2; tc=1 only while q=9.
REQ-032 From q=0, mode=00, x=0 -> q=9 next edge, tc=1 during q=0 cycle; then e=0 for 3 edges -> q stays 9, tc=0.
REQ-033 mode=01, d=7 -> q=7, err=0; then d=12 -> q=0, err=1; then mode=00 count 3 edges -> err stays 1; then load d=3 -> err=0.
REQ-034 Load d=3 (0011), mode=10, x=1 -> q=6; x=1 again -> q=12>=10 -> q=0, err=1; load d=8, x=0 rotate -> q=4, err=0.
REQ-035 Load d=6, mode=11 -> ~0110=1001=9, q=9 err=0; mode=11 again -> 0110=6; load d=2, mode=11 -> 13 -> q=0, err=1.
REQ-036 Count to q=5, assert reset with e=1, mode=00 -> q=0, err=0, tc=0 same edge; deassert -> q=1 next edge; repeat REQ-031 with WIDTH=3, MODULUS=8 -> full wrap 7->0.
